// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the BCD digit-stream to binary converter.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX        = 4'd9;
    localparam int         DEF_MAX_DIGITS = 4;
    localparam int         DEF_BIN_W      = 14;

    typedef enum logic [1:0] {
        ACC,
        DRAIN,
        HOLD
    } state_t;

endpackage

// File: rtl/bcd_mac10.sv
// Combinational multiply-by-ten-and-add: res = acc*10 + d, truncated to W bits.
module bcd_mac10 #(
    parameter int W = 14
) (
    input  logic [W-1:0] acc,
    input  logic [3:0]   d,
    output logic [W-1:0] res
);

    assign res = (acc << 3) + (acc << 1) + W'(d);

endmodule

// File: rtl/bcd_stream_to_bin.sv
// Accumulates a most-significant-first BCD digit stream into a binary value and
// presents one result per frame on a valid/ready output port.
module bcd_stream_to_bin
    import bcd_pkg::*;
#(
    parameter int MAX_DIGITS = DEF_MAX_DIGITS,
    parameter int BIN_W      = DEF_BIN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_digit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BIN_W-1:0] out_bin,
    output logic [2:0]       out_ndig,
    output logic             out_err
);

    state_t             state_q, state_n;
    logic [BIN_W-1:0]   acc_q, acc_n, mac_res;
    logic [2:0]         cnt_q, cnt_n, cnt_inc;
    logic               err_q, err_n;
    logic [BIN_W-1:0]   bin_q, bin_n;
    logic [2:0]         ndig_q, ndig_n;
    logic               oerr_q, oerr_n;
    logic               bad_digit, xfer;
    logic [3:0]         digit_d;

    assign bad_digit = (in_digit > BCD_MAX);
    assign digit_d   = bad_digit ? 4'd0 : in_digit;
    assign cnt_inc   = cnt_q + 3'd1;
    assign in_ready  = (state_q != HOLD) && !rst;
    assign xfer      = in_valid && in_ready;

    assign out_valid = (state_q == HOLD);
    assign out_bin   = bin_q;
    assign out_ndig  = ndig_q;
    assign out_err   = oerr_q;

    bcd_mac10 #(.W(BIN_W)) u_mac (
        .acc (acc_q),
        .d   (digit_d),
        .res (mac_res)
    );

    // Output registers load only on entry to HOLD, so they stay stable
    // through back-pressure and keep their values after the handshake.
    always_comb begin
        state_n = state_q;
        acc_n   = acc_q;
        cnt_n   = cnt_q;
        err_n   = err_q;
        bin_n   = bin_q;
        ndig_n  = ndig_q;
        oerr_n  = oerr_q;
        case (state_q)
            ACC: begin
                if (xfer) begin
                    acc_n = mac_res;
                    cnt_n = cnt_inc;
                    err_n = err_q | bad_digit;
                    if (in_last) begin
                        state_n = HOLD;
                        bin_n   = mac_res;
                        ndig_n  = cnt_inc;
                        oerr_n  = err_q | bad_digit;
                    end else if (cnt_inc == 3'(MAX_DIGITS)) begin
                        err_n   = 1'b1;
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (xfer && in_last) begin
                    state_n = HOLD;
                    bin_n   = acc_q;
                    ndig_n  = cnt_q;
                    oerr_n  = err_q;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_n = ACC;
                    acc_n   = '0;
                    cnt_n   = '0;
                    err_n   = 1'b0;
                end
            end
            default: state_n = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            bin_q   <= '0;
            ndig_q  <= '0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            acc_q   <= acc_n;
            cnt_q   <= cnt_n;
            err_q   <= err_n;
            bin_q   <= bin_n;
            ndig_q  <= ndig_n;
            oerr_q  <= oerr_n;
        end
    end

endmodule

// File: tb/tb_bcd_stream_to_bin.sv
// Directed bench for bcd_stream_to_bin: expected frame results go into a queue
// as stimulus is driven and are compared when the DUT hands a result over.
module tb_bcd_stream_to_bin;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_digit;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_bin;
    logic [2:0]  out_ndig;
    logic        out_err;

    typedef struct {
        logic [13:0] bin;
        logic [2:0]  ndig;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    bcd_stream_to_bin dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digit  (in_digit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_ndig  (out_ndig),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic pushExpected(input int bin, input int ndig, input bit err);
        exp_t e;
        e.bin  = 14'(bin);
        e.ndig = 3'(ndig);
        e.err  = err;
        sb.push_back(e);
    endtask

    // Drives one digit for one clock; returns at the following negedge.
    task automatic applyStimulus(input logic [3:0] d, input logic last);
        in_valid = 1'b1;
        in_digit = d;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((out_valid || !in_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_wait", 32'(n < 20), 32'd1);
    endtask

    // A result leaves the DUT on every valid & ready cycle; it must match the queue head.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("[TB] FAIL spurious_out observed=%0d expected=none", out_bin);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("out_bin", 32'(out_bin), 32'(e.bin));
                checkOutput("out_ndig", 32'(out_ndig), 32'(e.ndig));
                checkOutput("out_err", 32'(out_err), 32'(e.err));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_digit  = 4'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_bin", 32'(out_bin), 32'd0);
        checkOutput("rst_out_ndig", 32'(out_ndig), 32'd0);
        checkOutput("rst_out_err", 32'(out_err), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_ready", 32'(in_ready), 32'd1);

        $display("[TB] frame 1,2,3,4");
        pushExpected(1234, 4, 1'b0);
        applyStimulus(4'd1, 1'b0);
        applyStimulus(4'd2, 1'b0);
        applyStimulus(4'd3, 1'b0);
        checkOutput("valid_before_last", 32'(out_valid), 32'd0);
        applyStimulus(4'd4, 1'b1);
        checkOutput("valid_rise", 32'(out_valid), 32'd1);
        @(negedge clk);
        checkOutput("valid_fall", 32'(out_valid), 32'd0);
        checkOutput("ready_after_hs", 32'(in_ready), 32'd1);

        $display("[TB] frame 9,9,9,9 then 7");
        waitIdle();
        pushExpected(9999, 4, 1'b0);
        applyStimulus(4'd9, 1'b0);
        applyStimulus(4'd9, 1'b0);
        applyStimulus(4'd9, 1'b0);
        applyStimulus(4'd9, 1'b1);
        waitIdle();
        pushExpected(7, 1, 1'b0);
        applyStimulus(4'd7, 1'b1);
        waitIdle();
        checkOutput("retain_bin", 32'(out_bin), 32'd7);
        checkOutput("retain_ndig", 32'(out_ndig), 32'd1);

        $display("[TB] frame 4,B,2");
        pushExpected(402, 3, 1'b1);
        applyStimulus(4'd4, 1'b0);
        applyStimulus(4'hB, 1'b0);
        applyStimulus(4'd2, 1'b1);
        waitIdle();

        $display("[TB] frame 1..6 overflow");
        pushExpected(1234, 4, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            checkOutput("ready_overflow", 32'(in_ready), 32'd1);
            applyStimulus(4'(i), (i == 6));
        end
        waitIdle();

        $display("[TB] frame 5,6 with back-pressure");
        out_ready = 1'b0;
        pushExpected(56, 2, 1'b0);
        applyStimulus(4'd5, 1'b0);
        applyStimulus(4'd6, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_bin", 32'(out_bin), 32'd56);
            checkOutput("bp_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        checkOutput("hs_cycle_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkOutput("release_ready", 32'(in_ready), 32'd1);
        checkOutput("release_valid", 32'(out_valid), 32'd0);

        $display("[TB] reset mid-frame");
        applyStimulus(4'd3, 1'b0);
        applyStimulus(4'd3, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_ready", 32'(in_ready), 32'd0);
        checkOutput("midrst_bin", 32'(out_bin), 32'd0);
        rst = 1'b0;
        #1;
        pushExpected(8, 1, 1'b0);
        applyStimulus(4'd8, 1'b1);
        waitIdle();

        repeat (4) @(negedge clk);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_stream_to_bin.md
BCD_STREAM_TO_BIN -- requirements
Module: bcd_stream_to_bin

Interface
REQ-001 Parameter MAX_DIGITS, default 4: maximum BCD digits per frame.
REQ-002 Parameter BIN_W, default 14: result width; SHALL satisfy 2^BIN_W > 10^MAX_DIGITS - 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_digit/in_last valid this cycle.
REQ-006 in_ready  output  1  block accepts a digit this cycle.
REQ-007 in_digit  input  4  BCD digit, most significant digit first.
REQ-008 in_last  input  1  marks final digit of a frame.
REQ-009 out_valid  output  1  result held on out_* ports.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 out_bin  output  BIN_W  binary value of frame.
REQ-012 out_ndig  output  3  number of digits counted into out_bin (1..MAX_DIGITS).
REQ-013 out_err  output  1  frame had an invalid digit (>9) or exceeded MAX_DIGITS.

Function
REQ-014 Digit transfer SHALL occur only on a cycle where in_valid and in_ready are both 1.
REQ-015 State machine SHALL have exactly three states: ACC, DRAIN and HOLD.
REQ-016 in_ready SHALL be 1 in ACC and DRAIN, 0 in HOLD, and 0 while rst is high.
REQ-017 In ACC, each transfer SHALL update acc <= acc*10 + d and increment the digit count, where d = in_digit if in_digit <= 9, else d = 0 with the error flag set.
REQ-018 In ACC, a transfer with in_last=1 SHALL move to HOLD.
REQ-019 In ACC, the MAX_DIGITS-th transfer with in_last=0 SHALL set the error flag and move to DRAIN.
REQ-020 In DRAIN, transfers SHALL be discarded without changing acc or the count.
REQ-021 In DRAIN, a transfer with in_last=1 SHALL move to HOLD.
REQ-022 On entry to HOLD, out_valid SHALL rise the cycle after the last transfer, with out_bin, out_ndig and out_err registered.
REQ-023 out_bin, out_ndig and out_err SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 On an out_valid & out_ready cycle, the block SHALL return to ACC with acc, count and error cleared; out_valid SHALL fall the next cycle.
REQ-025 out_bin, out_ndig and out_err SHALL keep their last values after handshake until the next frame.
REQ-026 No digit SHALL be accepted in the cycle that the output handshake completes; minimum frame period is N+1 cycles for N digits.
REQ-027 out_bin SHALL be acc truncated to BIN_W bits; with the defaults this truncation never occurs.
REQ-028 Single-digit frame (first transfer has in_last=1) SHALL be legal: out_ndig=1.
REQ-029 in_valid=0 cycles mid-frame SHALL leave state unchanged (gaps allowed).

Reset
REQ-030 While rst=1 at a clock edge, the next state SHALL be ACC with acc=0, count=0 and error=0.
REQ-031 While rst=1 at a clock edge, the outputs SHALL become out_valid=0, out_bin=0, out_ndig=0 and out_err=0.
REQ-032 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending result without emitting it.
REQ-033 in_ready SHALL be 1 the first cycle after rst deasserts.

Structure
REQ-034 Shared package bcd_pkg SHALL hold BCD_MAX=9, the default MAX_DIGITS/BIN_W constants and the state enum (ACC, DRAIN, HOLD).
REQ-035 Sub-module bcd_mac10 SHALL be combinational, computing (acc<<3)+(acc<<1)+d, and SHALL be instantiated once.

Verification
REQ-036 After reset, feed digits 1,2,3,4 with in_last on 4, out_ready=1 -> out_bin=1234, out_ndig=4, out_err=0; out_valid is high for 1 cycle, rising the cycle after digit 4.
REQ-037 Feed digits 9,9,9,9 with last -> out_bin=9999; then digit 7 with last -> out_bin=7, out_ndig=1.
REQ-038 Feed digits 4,0xB,2 with last -> out_bin=402, out_ndig=3, out_err=1.
REQ-039 Feed digits 1,2,3,4,5,6 with last on 6 -> in_ready stays 1 through digit 6, then out_bin=1234, out_ndig=4, out_err=1.
REQ-040 Hold out_ready=0 for 5 cycles after frame 5,6 with last -> out_valid=1, out_bin=56 stable and in_ready=0 throughout; release -> in_ready=1 the next cycle.
REQ-041 Assert rst after digits 3,3 with no last, then feed 8 with last -> out_bin=8, out_ndig=1, and no result for 33 is ever emitted.
